// File: rtl/capture_sched_pkg.sv
// Shared types and constants for the capture scheduler.
//   state_e     : scheduler FSM states
//   err_code_e  : failure reason reported alongside the err pulse
//   CAM_*       : camera_sel encodings
//   rr_pick     : round-robin grant between the two pending requests
package capture_sched_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned TO_W_DEF  = 32;
  localparam int unsigned GAP_W_DEF = 16;

  localparam logic CAM_HAWK = 1'b0;
  localparam logic CAM_OWL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_ARM    = 3'd3,
    ST_RUN    = 3'd4,
    ST_GAP    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_LOCK     = 2'd1,
    ERR_START_TO = 2'd2,
    ERR_FRAME_TO = 2'd3
  } err_code_e;

  // Both pending: alternate away from the previous grant; otherwise the single requester.
  function automatic logic rr_pick(input logic pend_hawk, input logic pend_owl,
                                   input logic last_grant);
    if (pend_hawk && pend_owl) return ~last_grant;
    if (pend_hawk)             return CAM_HAWK;
    return CAM_OWL;
  endfunction

endpackage

// File: rtl/capture_scheduler_timer.sv
// Per-state cycle timer for the capture scheduler.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : synchronous clear (wins over enable)
//   en_i          : count one per cycle, saturating at all-ones
//   limit_i       : timeout limit, 0 disables the timeout
//   cnt_o         : cycles spent since the last clear (registered)
//   hit_c         : combinational, high on the cycle where cnt == limit-1
module sched_timer
  import capture_sched_pkg::*;
#(
  parameter int unsigned TO_W = TO_W_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            en_i,
  input  logic [TO_W-1:0] limit_i,
  output logic [TO_W-1:0] cnt_o,
  output logic            hit_c
);

  logic [TO_W-1:0] cnt_q;
  logic [TO_W-1:0] cnt_d;

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign hit_c = (limit_i != '0) && (cnt_q == (limit_i - TO_W'(1)));

endmodule

// File: rtl/capture_scheduler.sv
// Capture scheduler for the shared Hawk/Owl camera datapath.
// Arbitrates capture requests, drives camera_sel and the new_capture pulse,
// supervises each capture with start/frame timeouts, enforces an inter-frame
// gap and keeps frame/error counters.
//   sys_clk, sys_rst_n              : clock, async active-low reset
//   hawk_req, owl_req, abort        : 1-cycle request / abort pulses
//   cfg_start_to, cfg_frame_to      : timeouts in cycles, 0 = disabled
//   cfg_gap                         : idle cycles after each capture
//   serde_locked, camera_in_progress: status from the camera top
//   camera_sel, new_capture, busy   : control to camera top / software
//   done, done_cam, err, err_code   : completion reporting
//   hawk_frames, owl_frames         : wrapping success counters
//   err_count                       : saturating failure counter
module capture_scheduler
  import capture_sched_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned TO_W  = TO_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             hawk_req,
  input  logic             owl_req,
  input  logic             abort,
  input  logic [TO_W-1:0]  cfg_start_to,
  input  logic [TO_W-1:0]  cfg_frame_to,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             serde_locked,
  input  logic             camera_in_progress,
  output logic             camera_sel,
  output logic             new_capture,
  output logic             busy,
  output logic             done,
  output logic             done_cam,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] hawk_frames,
  output logic [CNT_W-1:0] owl_frames,
  output logic [CNT_W-1:0] err_count
);

  state_e           state_q,       state_d;
  logic             pend_hawk_q,   pend_hawk_d;
  logic             pend_owl_q,    pend_owl_d;
  logic             last_q,        last_d;
  logic             sel_q,         sel_d;
  logic             new_capture_q, new_capture_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;
  logic             done_cam_q,    done_cam_d;
  logic             err_q,         err_d;
  err_code_e        err_code_q,    err_code_d;
  logic [CNT_W-1:0] hawk_frames_q, hawk_frames_d;
  logic [CNT_W-1:0] owl_frames_q,  owl_frames_d;
  logic [CNT_W-1:0] err_count_q,   err_count_d;

  logic             grant;
  logic             tmr_clear;
  logic             tmr_en;
  logic [TO_W-1:0]  tmr_limit;
  logic [TO_W-1:0]  tmr_cnt;
  logic             tmr_hit;
  logic             gap_over;

  // Timer restarts on every state change; only the wait states carry a limit.
  assign tmr_clear = (state_d != state_q);
  assign tmr_en    = (state_q != ST_IDLE);

  always_comb begin
    tmr_limit = '0;
    case (state_q)
      ST_ARM:  tmr_limit = cfg_start_to;
      ST_RUN:  tmr_limit = cfg_frame_to;
      default: tmr_limit = '0;
    endcase
  end

  sched_timer #(
    .TO_W (TO_W)
  ) u_timer (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clear_i (tmr_clear),
    .en_i    (tmr_en),
    .limit_i (tmr_limit),
    .cnt_o   (tmr_cnt),
    .hit_c   (tmr_hit)
  );

  // A zero gap still spends one cycle in GAP.
  assign gap_over = (cfg_gap == '0) || (tmr_cnt >= (TO_W'(cfg_gap) - TO_W'(1)));
  assign grant    = rr_pick(pend_hawk_q, pend_owl_q, last_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    pend_hawk_d   = pend_hawk_q | hawk_req;
    pend_owl_d    = pend_owl_q  | owl_req;
    last_d        = last_q;
    sel_d         = sel_q;
    new_capture_d = 1'b0;
    done_d        = 1'b0;
    done_cam_d    = done_cam_q;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    hawk_frames_d = hawk_frames_q;
    owl_frames_d  = owl_frames_q;
    err_count_d   = err_count_q;

    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_GAP;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_hawk_q || pend_owl_q) state_d = ST_ARB;
        end
        ST_ARB: begin
          if (pend_hawk_q || pend_owl_q) begin
            sel_d   = grant;
            last_d  = grant;
            state_d = ST_SETTLE;
            if (grant == CAM_HAWK) pend_hawk_d = 1'b0;
            else                   pend_owl_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          // Second settle cycle decides: missing lock fails without pulsing.
          if (tmr_cnt == TO_W'(1)) begin
            if (!serde_locked) begin
              err_d       = 1'b1;
              err_code_d  = ERR_LOCK;
              done_cam_d  = sel_q;
              err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
              state_d     = ST_GAP;
            end else begin
              new_capture_d = 1'b1;
              state_d       = ST_ARM;
            end
          end
        end
        ST_ARM: begin
          if (camera_in_progress) begin
            state_d = ST_RUN;
          end else if (tmr_hit) begin
            err_d       = 1'b1;
            err_code_d  = ERR_START_TO;
            done_cam_d  = sel_q;
            err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
            state_d     = ST_GAP;
          end
        end
        ST_RUN: begin
          // Completion takes priority over a coincident frame timeout.
          if (!camera_in_progress) begin
            done_d     = 1'b1;
            err_code_d = ERR_NONE;
            done_cam_d = sel_q;
            if (sel_q == CAM_HAWK) hawk_frames_d = hawk_frames_q + CNT_W'(1);
            else                   owl_frames_d  = owl_frames_q  + CNT_W'(1);
            state_d = ST_GAP;
          end else if (tmr_hit) begin
            err_d       = 1'b1;
            err_code_d  = ERR_FRAME_TO;
            done_cam_d  = sel_q;
            err_count_d = (&err_count_q) ? err_count_q : err_count_q + CNT_W'(1);
            state_d     = ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_over) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Abort flushes pending work, including a request arriving the same cycle.
    if (abort) begin
      pend_hawk_d = 1'b0;
      pend_owl_d  = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      pend_hawk_q   <= 1'b0;
      pend_owl_q    <= 1'b0;
      last_q        <= CAM_OWL;  // first contested grant goes to Hawk
      sel_q         <= CAM_HAWK;
      new_capture_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      done_cam_q    <= CAM_HAWK;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
      hawk_frames_q <= '0;
      owl_frames_q  <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_hawk_q   <= pend_hawk_d;
      pend_owl_q    <= pend_owl_d;
      last_q        <= last_d;
      sel_q         <= sel_d;
      new_capture_q <= new_capture_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      done_cam_q    <= done_cam_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
      hawk_frames_q <= hawk_frames_d;
      owl_frames_q  <= owl_frames_d;
      err_count_q   <= err_count_d;
    end
  end

  assign camera_sel  = sel_q;
  assign new_capture = new_capture_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign done_cam    = done_cam_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign hawk_frames = hawk_frames_q;
  assign owl_frames  = owl_frames_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_capture_scheduler.sv
// Directed self-checking bench for capture_scheduler.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_capture_scheduler;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned TO_W  = 32;
  localparam int unsigned GAP_W = 16;
  // Negedges from the end of a request pulse to new_capture being visible.
  localparam int NC_LAT = 4;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             hawk_req, owl_req, abort;
  logic [TO_W-1:0]  cfg_start_to, cfg_frame_to;
  logic [GAP_W-1:0] cfg_gap;
  logic             serde_locked, camera_in_progress;
  logic             camera_sel, new_capture, busy, done, done_cam, err;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] hawk_frames, owl_frames, err_count;
  logic [55:0]      all_outs;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  assign all_outs = {camera_sel, new_capture, busy, done, done_cam, err, err_code,
                     hawk_frames, owl_frames, err_count};

  capture_scheduler #(.CNT_W(CNT_W), .TO_W(TO_W), .GAP_W(GAP_W)) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .hawk_req           (hawk_req),
    .owl_req            (owl_req),
    .abort              (abort),
    .cfg_start_to       (cfg_start_to),
    .cfg_frame_to       (cfg_frame_to),
    .cfg_gap            (cfg_gap),
    .serde_locked       (serde_locked),
    .camera_in_progress (camera_in_progress),
    .camera_sel         (camera_sel),
    .new_capture        (new_capture),
    .busy               (busy),
    .done               (done),
    .done_cam           (done_cam),
    .err                (err),
    .err_code           (err_code),
    .hawk_frames        (hawk_frames),
    .owl_frames         (owl_frames),
    .err_count          (err_count)
  );

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    hawk_req = 0; owl_req = 0; abort = 0;
    serde_locked = 1'b1; camera_in_progress = 1'b0;
    repeat (2) tick();
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_req(input logic h, input logic o);
    hawk_req = h; owl_req = o;
    tick();
    hawk_req = 0; owl_req = 0;
  endtask

  // Wait (bounded) for 0:new_capture 1:done 2:err 3:idle; n = -1 on timeout.
  task automatic wait_sig(input int which, input int budget, output int n, output int nc_seen);
    bit hit;
    hit = 0; n = 0; nc_seen = 0;
    while (!hit && n < budget) begin
      tick();
      n++;
      nc_seen += int'(new_capture);
      case (which)
        0:       hit = new_capture;
        1:       hit = done;
        2:       hit = err;
        default: hit = !busy;
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    hawk_req = 0; owl_req = 0; abort = 0;
    cfg_start_to = '0; cfg_frame_to = '0; cfg_gap = 16'd2;
    serde_locked = 1'b1; camera_in_progress = 1'b0;
    #1;
    checks++;
    if (all_outs !== 56'd0) begin
      errors++; $display("FAIL reset_outs: got %h expected 0", all_outs);
    end
    repeat (2) tick();
    sys_rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_hawk_capture();
    int n, nc;
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 50, n, nc);
    checks++;
    if (n !== NC_LAT) begin
      errors++; $display("FAIL hawk_nc_latency: got %0d expected %0d", n, NC_LAT);
    end
    checks++;
    if (camera_sel !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL hawk_sel_busy: got sel=%b busy=%b expected sel=0 busy=1", camera_sel, busy);
    end
    tick();
    checks++;
    if (new_capture !== 1'b0) begin
      errors++; $display("FAIL hawk_nc_pulse_width: got %b expected 0", new_capture);
    end
    repeat (4) tick();
    camera_in_progress = 1'b1;
    repeat (100) tick();
    camera_in_progress = 1'b0;
    wait_sig(1, 20, n, nc);
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL hawk_done_latency: got %0d expected 1", n);
    end
    checks++;
    if (hawk_frames !== 16'd1 || owl_frames !== 16'd0 || done_cam !== 1'b0 || err_code !== 2'd0 || err !== 1'b0) begin
      errors++; $display("FAIL hawk_done_status: got hf=%0d of=%0d cam=%b code=%0d err=%b expected 1 0 0 0 0",
                         hawk_frames, owl_frames, done_cam, err_code, err);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL hawk_done_pulse_width: got %b expected 0", done);
    end
    wait_sig(3, 50, n, nc);
    checks++;
    if (n < 0) begin
      errors++; $display("FAIL hawk_return_idle: got timeout expected idle");
    end
  endtask

  task automatic test_back_to_back();
    int n, nc;
    do_reset();
    cfg_gap = 16'd8;
    pulse_req(1'b1, 1'b1);
    wait_sig(0, 50, n, nc);
    checks++;
    if (n !== NC_LAT || camera_sel !== 1'b0) begin
      errors++; $display("FAIL b2b_first_grant: got n=%0d sel=%b expected n=%0d sel=0", n, camera_sel, NC_LAT);
    end
    tick();
    camera_in_progress = 1'b1;
    tick();
    camera_in_progress = 1'b0;
    wait_sig(1, 20, n, nc);
    checks++;
    if (n !== 1 || done_cam !== 1'b0) begin
      errors++; $display("FAIL b2b_first_done: got n=%0d cam=%b expected n=1 cam=0", n, done_cam);
    end
    wait_sig(0, 50, n, nc);
    checks++;
    if (n !== 12 || camera_sel !== 1'b1) begin
      errors++; $display("FAIL b2b_second_grant: got n=%0d sel=%b expected n=12 sel=1", n, camera_sel);
    end
    tick();
    camera_in_progress = 1'b1;
    repeat (3) tick();
    camera_in_progress = 1'b0;
    wait_sig(1, 20, n, nc);
    checks++;
    if (n !== 1 || owl_frames !== 16'd1 || hawk_frames !== 16'd1 || done_cam !== 1'b1) begin
      errors++; $display("FAIL b2b_second_done: got n=%0d of=%0d hf=%0d cam=%b expected 1 1 1 1",
                         n, owl_frames, hawk_frames, done_cam);
    end
    wait_sig(3, 50, n, nc);
  endtask

  task automatic test_lock_err();
    int n, nc;
    serde_locked = 1'b0;
    pulse_req(1'b0, 1'b1);
    wait_sig(2, 50, n, nc);
    checks++;
    if (n !== NC_LAT || nc !== 0) begin
      errors++; $display("FAIL lock_err_timing: got n=%0d nc=%0d expected n=%0d nc=0", n, nc, NC_LAT);
    end
    checks++;
    if (err_code !== 2'd1 || err_count !== 16'd1 || done_cam !== 1'b1 || done !== 1'b0 || camera_sel !== 1'b1) begin
      errors++; $display("FAIL lock_err_status: got code=%0d ec=%0d cam=%b done=%b sel=%b expected 1 1 1 0 1",
                         err_code, err_count, done_cam, done, camera_sel);
    end
    wait_sig(3, 50, n, nc);
    checks++;
    if (nc !== 0 || n < 0) begin
      errors++; $display("FAIL lock_err_no_capture: got nc=%0d n=%0d expected nc=0", nc, n);
    end
    serde_locked = 1'b1;
  endtask

  task automatic test_start_timeout();
    int n, nc;
    cfg_start_to = 32'd20;
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 50, n, nc);
    wait_sig(2, 100, n, nc);
    checks++;
    if (n !== 20) begin
      errors++; $display("FAIL start_to_latency: got %0d expected 20", n);
    end
    checks++;
    if (err_code !== 2'd2 || err_count !== 16'd2 || done_cam !== 1'b0) begin
      errors++; $display("FAIL start_to_status: got code=%0d ec=%0d cam=%b expected 2 2 0",
                         err_code, err_count, done_cam);
    end
    wait_sig(3, 50, n, nc);
    cfg_start_to = '0;
  endtask

  task automatic test_frame_timeout();
    int n, nc;
    cfg_frame_to = 32'd50;
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 50, n, nc);
    repeat (2) tick();
    camera_in_progress = 1'b1;
    wait_sig(2, 200, n, nc);
    checks++;
    if (n !== 51) begin
      errors++; $display("FAIL frame_to_latency: got %0d expected 51", n);
    end
    checks++;
    if (err_code !== 2'd3 || err_count !== 16'd3 || hawk_frames !== 16'd1) begin
      errors++; $display("FAIL frame_to_status: got code=%0d ec=%0d hf=%0d expected 3 3 1",
                         err_code, err_count, hawk_frames);
    end
    camera_in_progress = 1'b0;
    wait_sig(3, 50, n, nc);
    // Recovery capture whose in_progress falls on the timeout cycle: done wins.
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 50, n, nc);
    tick();
    camera_in_progress = 1'b1;
    repeat (50) tick();
    camera_in_progress = 1'b0;
    wait_sig(1, 20, n, nc);
    checks++;
    if (n !== 1 || err !== 1'b0) begin
      errors++; $display("FAIL frame_to_tie_done: got n=%0d err=%b expected n=1 err=0", n, err);
    end
    checks++;
    if (hawk_frames !== 16'd2 || err_code !== 2'd0 || err_count !== 16'd3) begin
      errors++; $display("FAIL frame_to_recovery: got hf=%0d code=%0d ec=%0d expected 2 0 3",
                         hawk_frames, err_code, err_count);
    end
    wait_sig(3, 50, n, nc);
    cfg_frame_to = '0;
  endtask

  task automatic test_abort();
    int n, nc, flags;
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 50, n, nc);
    tick();
    camera_in_progress = 1'b1;
    repeat (3) tick();
    abort = 1'b1; owl_req = 1'b1;
    tick();
    abort = 1'b0; owl_req = 1'b0;
    camera_in_progress = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL abort_to_gap: got busy=%b done=%b err=%b expected 1 0 0", busy, done, err);
    end
    flags = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      flags += int'(done) + int'(err) + int'(new_capture) + int'(busy && i >= 15);
    end
    checks++;
    if (flags !== 0) begin
      errors++; $display("FAIL abort_quiet: got %0d events expected 0", flags);
    end
    checks++;
    if (hawk_frames !== 16'd2 || owl_frames !== 16'd1 || err_count !== 16'd3 || err_code !== 2'd0) begin
      errors++; $display("FAIL abort_counters: got hf=%0d of=%0d ec=%0d code=%0d expected 2 1 3 0",
                         hawk_frames, owl_frames, err_count, err_code);
    end
  endtask

  task automatic test_async_reset();
    int n, nc;
    pulse_req(1'b1, 1'b0);
    wait_sig(0, 50, n, nc);
    tick();
    camera_in_progress = 1'b1;
    repeat (3) tick();
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== 56'd0) begin
      errors++; $display("FAIL async_reset_outs: got %h expected 0", all_outs);
    end
    tick();
    camera_in_progress = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || hawk_frames !== 16'd0) begin
      errors++; $display("FAIL async_reset_after: got busy=%b hf=%0d expected 0 0", busy, hawk_frames);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_hawk_capture();
    test_back_to_back();
    test_lock_err();
    test_start_timeout();
    test_frame_timeout();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
